pipelined_scale_add: RTL and testbench

//   Streaming datapath that computes O = I0 + I1*COEFF modulo 2^WIDTH.
//   Two register stages with valid/ready flow control at both ends.

---
 rtl/pipelined_scale_add.sv | 102 ++++++++++
 tb/tb_pipelined_scale_add.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_scale_add.sv
// ============================================================================
// Module   : pipelined_scale_add
// Brief    : Two-stage valid/ready streaming datapath, O = I0 + I1*COEFF
//            (mod 2^WIDTH), with an optional per-beat running accumulator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipelined_scale_add #(
    parameter int WIDTH = 8,
    parameter int COEFF = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             acc_mode,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] O
);

    localparam logic [WIDTH-1:0] c_coeff = WIDTH'(COEFF);

    // Stage-1 registers
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_p;
    logic [WIDTH-1:0] r_s1_i0;
    logic             r_s1_acc_mode;
    logic             r_s1_acc_clear;

    // Stage-2 / output registers
    logic             r_out_valid;
    logic [WIDTH-1:0] r_o;
    logic [WIDTH-1:0] r_acc;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_p1;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_sum;

    assign w_s2_adv  = !r_out_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv && !RESET;
    assign w_in_fire = in_valid && in_ready;

    // The low WIDTH bits of the full product equal a WIDTH-bit multiply.
    assign w_p1 = I1 * c_coeff;

    always_comb begin
        w_base = r_s1_i0;
        if (r_s1_acc_mode) begin
            w_base = r_s1_acc_clear ? '0 : r_acc;
        end
    end

    assign w_sum = w_base + r_s1_p;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1_valid     <= 1'b0;
            r_s1_p         <= '0;
            r_s1_i0        <= '0;
            r_s1_acc_mode  <= 1'b0;
            r_s1_acc_clear <= 1'b0;
            r_out_valid    <= 1'b0;
            r_o            <= '0;
            r_acc          <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_in_fire;
            end
            if (w_in_fire) begin
                r_s1_p         <= w_p1;
                r_s1_i0        <= I0;
                r_s1_acc_mode  <= acc_mode;
                r_s1_acc_clear <= acc_clear;
            end
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
            end
            // acc is written on the same edge as O so a following beat sees it.
            if (r_s1_valid && w_s2_adv) begin
                r_o <= w_sum;
                if (r_s1_acc_mode) begin
                    r_acc <= w_sum;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign O         = r_o;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_scale_add.sv
// Bench for pipelined_scale_add: directed cases with literal expectations plus
// randomized valid/ready traffic checked against a queue-based model.
`default_nettype none

module tb_pipelined_scale_add;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] I0;
    logic [7:0] I1;
    logic       acc_mode;
    logic       acc_clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] O;

    pipelined_scale_add #(.WIDTH(8), .COEFF(3)) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready),
        .I0(I0), .I1(I1), .acc_mode(acc_mode), .acc_clear(acc_clear),
        .out_valid(out_valid), .out_ready(out_ready), .O(O)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    int   exp_q[$];
    int   m_acc = 0;
    int   last_out = -1;
    int   n_out = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_o = '0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Reference: result of a beat from plain arithmetic, in acceptance order.
    function automatic int model_beat(input int a, input int b, input bit am, input bit ac);
        int base;
        int s;
        base = am ? (ac ? 0 : m_acc) : a;
        s = (base + b * 3) % 256;
        if (am) m_acc = s;
        return s;
    endfunction

    // Monitor: handshakes and output checks, sampled on the falling edge.
    always @(negedge CLK) begin
        if (RESET) begin
            check("in_ready_during_reset", int'(in_ready), 0);
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(O), int'(prev_o));
            end
            if (in_valid && in_ready)
                exp_q.push_back(model_beat(int'(I0), int'(I1), acc_mode, acc_clear));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 1, 0);
                end else begin
                    check("stream_data", int'(O), exp_q.pop_front());
                end
                last_out = int'(O);
                n_out++;
            end
            prev_stall = out_valid && !out_ready;
            prev_o     = O;
        end
    end

    task automatic send(input int a, input int b, input bit am, input bit ac);
        int k;
        in_valid = 1; I0 = 8'(a); I1 = 8'(b); acc_mode = am; acc_clear = ac;
        k = 0;
        @(negedge CLK);
        while (!in_ready && k < 50) begin
            k++;
            @(negedge CLK);
        end
        if (k >= 50) check("send_timeout", 1, 0);
        @(posedge CLK); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int k;
        out_ready = 1;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge CLK); #1;
            k++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge CLK); #1;
    endtask

    task automatic send_check(input int a, input int b, input bit am, input bit ac,
                              input string name, input int lit);
        send(a, b, am, ac);
        drain();
        check(name, last_out, lit);
    endtask

    initial begin
        int accepts;
        int cyc;
        bit fire;
        RESET = 1; in_valid = 0; I0 = 0; I1 = 0; acc_mode = 0; acc_clear = 0; out_ready = 1;
        repeat (2) @(posedge CLK);
        #1 RESET = 0;
        @(negedge CLK);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_O", int'(O), 0);
        check("ready_after_reset", int'(in_ready), 1);

        // Basic value and 2-cycle latency
        @(posedge CLK); #1;
        in_valid = 1; I0 = 5; I1 = 7; acc_mode = 0; acc_clear = 0;
        @(negedge CLK);
        check("accept_first", int'(in_ready), 1);
        @(posedge CLK); #1 in_valid = 0;
        @(negedge CLK);
        check("latency_not_early", int'(out_valid), 0);
        @(negedge CLK);
        check("latency_valid", int'(out_valid), 1);
        check("basic_5_7", int'(O), 26);
        drain();

        // Wrap and product truncation
        send_check(8'hF0, 8'h10, 0, 0, "wrap_sum", 8'h20);
        send_check(8'h00, 8'h80, 0, 0, "trunc_product", 8'h80);

        // Backpressure: 6 beats with out_ready low for 5 cycles
        out_ready = 0;
        accepts = 0;
        in_valid = 1; acc_mode = 0; acc_clear = 0;
        I0 = 8'd10; I1 = 8'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            fire = in_valid && in_ready;
            @(posedge CLK); #1;
            if (fire) begin
                accepts++;
                I0 = 8'(10 + accepts); I1 = 8'(accepts + 1);
            end
        end
        check("stall_accepts", accepts, 2);
        @(negedge CLK);
        check("stall_in_ready_low", int'(in_ready), 0);
        @(posedge CLK); #1;
        out_ready = 1;
        cyc = 0;
        while (accepts < 6 && cyc < 50) begin
            @(negedge CLK);
            fire = in_valid && in_ready;
            @(posedge CLK); #1;
            if (fire) begin
                accepts++;
                I0 = 8'(10 + accepts); I1 = 8'(accepts + 1);
            end
            cyc++;
        end
        in_valid = 0;
        check("stall_all_accepted", accepts, 6);
        drain();
        check("stall_last_beat", last_out, 15 + 18);

        // Accumulator sequence
        send_check(0, 1, 1, 1, "acc_first", 3);
        send_check(0, 2, 1, 0, "acc_second", 9);
        send_check(0, 4, 1, 0, "acc_third", 21);
        send_check(1, 1, 0, 1, "acc_bypass", 4);
        send_check(0, 0, 1, 0, "acc_kept_21", 21);

        // Reset with beats in flight
        out_ready = 0;
        send(7, 7, 1, 0);
        send(8, 8, 0, 0);
        RESET = 1;
        @(posedge CLK); #1;
        RESET = 0;
        exp_q.delete();
        m_acc = 0;
        out_ready = 1;
        @(negedge CLK);
        check("reset_flush_valid", int'(out_valid), 0);
        send_check(1, 1, 0, 0, "post_reset_beat", 4);
        send_check(0, 1, 1, 0, "post_reset_acc_zero", 3);

        // Randomized traffic
        accepts = 0;
        cyc = 0;
        in_valid = 0;
        while (accepts < 10000 && cyc < 60000) begin
            @(negedge CLK);
            fire = in_valid && in_ready;
            if (fire) accepts++;
            @(posedge CLK); #1;
            if (fire || !in_valid) begin
                in_valid  = ($urandom_range(3) != 0);
                I0        = 8'($urandom);
                I1        = 8'($urandom);
                acc_mode  = ($urandom_range(2) == 0);
                acc_clear = ($urandom_range(7) == 0);
            end
            out_ready = ($urandom_range(3) != 0);
            cyc++;
        end
        in_valid = 0;
        check("random_beats_accepted", accepts, 10000);
        drain();
        check("queue_empty_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
